seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector; next generation of the fixed 6-bit Moore sequence detector.
- Pattern, pattern length and overlap mode are run-time configurable.
- Input bits are qualified by a valid strobe, and the block keeps a saturating match counter.
- Sits on a serial bitstream path; `detect` feeds downstream framing/alignment logic.

---
 rtl/seq_detector_param_if.sv | 27 ++
 rtl/seq_detector_param.sv | 85 ++++++++
 tb/tb_seq_detector_param.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - configuration, bitstream and result signals of the pattern detector
interface seq_detector_param_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;
  logic               count_clr;
  logic               detect;
  logic [CNT_W-1:0]   match_count;
  logic               armed;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit, count_clr,
    input  detect, match_count, armed
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit, count_clr,
    output detect, match_count, armed
  );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - run-time configurable serial bit-pattern detector with match counter
module seq_detector_param #(
  parameter int               MAX_LEN         = 16,
  parameter int               LEN_W           = 5,
  parameter int               CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 16'b0000000000001100,
  parameter int               DEFAULT_LEN     = 6,
  parameter bit               DEFAULT_OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  seq_detector_param_if.slave bus
);
  logic [MAX_LEN-1:0] pattern_r;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] nh;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   nf;
  logic [LEN_W-1:0]   cfg_len_c;
  logic               overlap_r;
  logic               detect_r;
  logic               hit;
  logic               accept_hit;
  logic [CNT_W-1:0]   count_r;

  always_comb begin
    nh = (hist << 1) | {{(MAX_LEN-1){1'b0}}, bus.in_bit};
    nf = (fill >= LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    // Compare only the low len_r bits of history against the pattern.
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_r));
    end
    hit = (nf >= len_r) && ((nh & mask) == (pattern_r & mask));
    accept_hit = bus.in_valid && !bus.cfg_load && hit;

    if (bus.cfg_len == '0) begin
      cfg_len_c = LEN_W'(1);
    end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
      cfg_len_c = LEN_W'(MAX_LEN);
    end else begin
      cfg_len_c = bus.cfg_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_r <= DEFAULT_PATTERN;
      len_r     <= LEN_W'(DEFAULT_LEN);
      overlap_r <= DEFAULT_OVERLAP;
      hist      <= '0;
      fill      <= '0;
      detect_r  <= 1'b0;
      count_r   <= '0;
    end else begin
      if (bus.count_clr) begin
        count_r <= '0;
      end else if (accept_hit && (count_r != '1)) begin
        count_r <= count_r + CNT_W'(1);
      end

      if (bus.cfg_load) begin
        pattern_r <= bus.cfg_pattern;
        len_r     <= cfg_len_c;
        overlap_r <= bus.cfg_overlap;
        hist      <= '0;
        fill      <= '0;
        detect_r  <= 1'b0;
      end else if (bus.in_valid) begin
        hist     <= nh;
        detect_r <= hit;
        // Non-overlap restarts the fill so the next match needs len_r fresh bits.
        fill     <= (hit && !overlap_r) ? '0 : nf;
      end else begin
        detect_r <= 1'b0;
      end
    end
  end

  assign bus.detect      = detect_r;
  assign bus.match_count = count_r;
  assign bus.armed       = (fill >= len_r);
endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  seq_detector_param_if #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8)) bus ();

  seq_detector_param dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic b);
    bus.in_valid = v;
    bus.in_bit   = b;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.cfg_load  = 1'b0;
    bus.count_clr = 1'b0;
  endtask

  task automatic load(input logic [15:0] pat, input logic [4:0] len, input logic ovl);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.count_clr   = 1'b1;
    step(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;
    tests++;
    if (bus.detect !== 1'b0) begin fails++; $display("FAIL reset_detect got %0b want 0", bus.detect); end
    tests++;
    if (bus.match_count !== 8'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.match_count); end
    tests++;
    if (bus.armed !== 1'b0) begin fails++; $display("FAIL reset_armed got %0b want 0", bus.armed); end
  endtask

  task automatic test_defaults_overlap();
    logic [9:0] stream;
    stream = 10'b0011001100;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, stream[9-i]);
      tests++;
      if (bus.detect !== ((i == 5) || (i == 9))) begin
        fails++; $display("FAIL ovl_detect bit%0d got %0b want %0b", i+1, bus.detect, (i == 5) || (i == 9));
      end
      tests++;
      if (bus.armed !== (i >= 5)) begin
        fails++; $display("FAIL ovl_armed bit%0d got %0b want %0b", i+1, bus.armed, i >= 5);
      end
    end
    tests++;
    if (bus.match_count !== 8'd2) begin fails++; $display("FAIL ovl_count got %0d want 2", bus.match_count); end
  endtask

  task automatic test_non_overlap();
    logic [9:0] stream;
    stream = 10'b0011001100;
    load(16'b001100, 5'd6, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, stream[9-i]);
      tests++;
      if (bus.detect !== (i == 5)) begin
        fails++; $display("FAIL novl_detect bit%0d got %0b want %0b", i+1, bus.detect, i == 5);
      end
      tests++;
      if (bus.armed !== 1'b0) begin
        fails++; $display("FAIL novl_armed bit%0d got %0b want 0", i+1, bus.armed);
      end
    end
    tests++;
    if (bus.match_count !== 8'd1) begin fails++; $display("FAIL novl_count got %0d want 1", bus.match_count); end
  endtask

  task automatic test_valid_gaps();
    load(16'b001100, 5'd6, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1);
      tests++;
      if (bus.detect !== 1'b0) begin fails++; $display("FAIL gap_detect gap%0d got %0b want 0", g, bus.detect); end
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    tests++;
    if (bus.detect !== 1'b0) begin fails++; $display("FAIL gap_early got %0b want 0", bus.detect); end
    step(1'b1, 1'b0);
    tests++;
    if (bus.detect !== 1'b1) begin fails++; $display("FAIL gap_hit got %0b want 1", bus.detect); end
    step(1'b0, 1'b0);
    tests++;
    if (bus.detect !== 1'b0) begin fails++; $display("FAIL gap_pulse_width got %0b want 0", bus.detect); end
    tests++;
    if (bus.match_count !== 8'd1) begin fails++; $display("FAIL gap_count got %0d want 1", bus.match_count); end
  endtask

  task automatic test_saturation();
    load(16'h0001, 5'd1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1);
      if (i == 1) begin
        tests++;
        if (bus.detect !== 1'b1) begin fails++; $display("FAIL sat_back_to_back got %0b want 1", bus.detect); end
      end
      if (i == 254) begin
        tests++;
        if (bus.match_count !== 8'd255) begin fails++; $display("FAIL sat_reach got %0d want 255", bus.match_count); end
      end
    end
    tests++;
    if (bus.match_count !== 8'd255) begin fails++; $display("FAIL sat_hold got %0d want 255", bus.match_count); end
    bus.count_clr = 1'b1;
    step(1'b1, 1'b1);
    tests++;
    if (bus.match_count !== 8'd0) begin fails++; $display("FAIL clr_priority got %0d want 0", bus.match_count); end
    tests++;
    if (bus.detect !== 1'b1) begin fails++; $display("FAIL clr_detect got %0b want 1", bus.detect); end
    step(1'b1, 1'b1);
    tests++;
    if (bus.match_count !== 8'd1) begin fails++; $display("FAIL clr_resume got %0d want 1", bus.match_count); end
  endtask

  task automatic test_clamp();
    logic [3:0] bits;
    bits = 4'b1101;
    load(16'h0001, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits[3-i]);
      tests++;
      if (bus.detect !== bits[3-i]) begin
        fails++; $display("FAIL clamp0_detect bit%0d got %0b want %0b", i+1, bus.detect, bits[3-i]);
      end
    end
    load(16'hFFFF, 5'd31, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    tests++;
    if (bus.armed !== 1'b0) begin fails++; $display("FAIL clamp31_armed15 got %0b want 0", bus.armed); end
    tests++;
    if (bus.detect !== 1'b0) begin fails++; $display("FAIL clamp31_detect15 got %0b want 0", bus.detect); end
    step(1'b1, 1'b1);
    tests++;
    if (bus.armed !== 1'b1) begin fails++; $display("FAIL clamp31_armed16 got %0b want 1", bus.armed); end
    tests++;
    if (bus.detect !== 1'b1) begin fails++; $display("FAIL clamp31_detect16 got %0b want 1", bus.detect); end
  endtask

  task automatic test_reset_mid();
    logic [4:0]  part;
    logic [9:0]  stream;
    part   = 5'b00110;
    stream = 10'b0011001100;
    load(16'b001100, 5'd6, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, part[4-i]);
    // The completing bit arrives with reset high and must be swallowed.
    reset = 1'b1;
    step(1'b1, 1'b0);
    reset = 1'b0;
    tests++;
    if (bus.detect !== 1'b0) begin fails++; $display("FAIL rst_mid_detect got %0b want 0", bus.detect); end
    tests++;
    if (bus.match_count !== 8'd0) begin fails++; $display("FAIL rst_mid_count got %0d want 0", bus.match_count); end
    step(1'b1, 1'b0);
    tests++;
    if (bus.detect !== 1'b0) begin fails++; $display("FAIL rst_mid_after got %0b want 0", bus.detect); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, stream[9-i]);
      tests++;
      if (bus.detect !== ((i == 5) || (i == 9))) begin
        fails++; $display("FAIL rst_defaults bit%0d got %0b want %0b", i+1, bus.detect, (i == 5) || (i == 9));
      end
    end
    tests++;
    if (bus.match_count !== 8'd2) begin fails++; $display("FAIL rst_defaults_count got %0d want 2", bus.match_count); end
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    reset           = 1'b1;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_bit      = 1'b0;
    bus.count_clr   = 1'b0;
    test_reset();
    test_defaults_overlap();
    test_non_overlap();
    test_valid_gaps();
    test_saturation();
    test_clamp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
